// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive FIFO; the head is presented on dout, and dout is zero while empty.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver: synchroniser, bit-timing FSM and sticky error flags in front of an rx_fifo.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          rd_en,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int BW = $clog2(DATA_BITS);

  rx_state_t            state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push, frame_set, overrun_set, expired;
  logic                 fifo_empty, fifo_full;

  // fill_q marks when rx_s carries a real RX sample rather than the reset value,
  // so a line held low across reset can never arm the receiver.
  always_comb begin
    state_d     = state_q;
    fill_d      = {fill_q[0], 1'b1};
    armed_d     = armed_q;
    timer_d     = timer_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_set   = 1'b0;
    expired     = (timer_q == '0);
    if (state_q != IDLE && !expired) timer_d = timer_q - DIV_W'(1);
    case (state_q)
      IDLE: begin
        if (rx_s_q && fill_q[1]) armed_d = 1'b1;
        if (armed_q && !rx_s_q) begin
          div_d   = baud_div;
          timer_d = (baud_div >> 1) - DIV_W'(1);
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          if (rx_s_q) begin
            armed_d = 1'b0;
            state_d = IDLE;
          end else begin
            timer_d   = div_q - DIV_W'(1);
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          timer_d   = div_q - DIV_W'(1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (expired) begin
          if (rx_s_q) push = 1'b1;
          else        frame_set = 1'b1;
          armed_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error event in the same cycle as clr_err leaves the flag set.
  always_comb begin
    overrun_set = push && fifo_full && !rd_en;
    overrun_d   = clr_err ? 1'b0 : overrun_q;
    frame_err_d = clr_err ? 1'b0 : frame_err_q;
    if (overrun_set) overrun_d = 1'b1;
    if (frame_set)   frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      timer_q     <= '0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= RX;
      rx_s_q      <= sync1_q;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      timer_q     <= timer_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift_q),
    .pop   (rd_en),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed scoreboard bench for uart_rx_buffered: ideal serial frames in, FIFO pops compared against a queue.
module tb_uart_rx_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] baudDiv;
  logic        rdEn;
  logic        clrErr;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [3:0]  fifoCount;
  logic        overrun;
  logic        frameErr;

  int          passed = 0;
  int          total  = 0;
  logic [7:0]  expQ[$];
  logic [7:0]  headByte;

  always #5 clk = ~clk;

  uart_rx_buffered #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (rx),
    .baud_div   (baudDiv),
    .rd_en      (rdEn),
    .rx_data    (rxData),
    .rx_valid   (rxValid),
    .fifo_count (fifoCount),
    .overrun    (overrun),
    .frame_err  (frameErr),
    .clr_err    (clrErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one 10-bit frame starting just after a rising edge, each bit lasting div clocks.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int div);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (div) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic popByte(input string tag);
    logic [7:0] exp;
    exp = expQ.pop_front();
    checkOutput({tag, "_valid"}, rxValid, 1);
    checkOutput({tag, "_data"}, rxData, exp);
    rdEn = 1'b1;
    @(posedge clk);
    #1;
    rdEn = 1'b0;
  endtask

  task automatic pulseClr();
    clrErr = 1'b1;
    @(posedge clk);
    #1;
    clrErr = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    baudDiv = 16'd16;
    rdEn    = 1'b0;
    clrErr  = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(5);

    checkOutput("reset_valid", rxValid, 0);
    checkOutput("reset_count", fifoCount, 0);
    checkOutput("reset_data", rxData, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_frame_err", frameErr, 0);

    // Single frame, with the valid rise expected 155 clocks after the falling edge.
    fork
      applyStimulus(8'hA5, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        repeat (154) @(posedge clk);
        #1;
        checkOutput("t1_before_rise", rxValid, 0);
        @(posedge clk);
        #1;
        checkOutput("t1_at_rise", rxValid, 1);
      end
    join
    expQ.push_back(8'hA5);
    idle(4);
    checkOutput("t1_count", fifoCount, 1);
    popByte("t1_pop");
    checkOutput("t1_valid_after_pop", rxValid, 0);
    checkOutput("t1_count_after_pop", fifoCount, 0);

    // Nine frames with no reads: the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(i), 1'b1, 16);
      if (i < 8) expQ.push_back(8'(i));
    end
    idle(4);
    checkOutput("t2_count_full", fifoCount, 8);
    checkOutput("t2_overrun", overrun, 1);
    checkOutput("t2_frame_err", frameErr, 0);
    for (int i = 0; i < 8; i++) popByte("t2_pop");
    checkOutput("t2_empty", rxValid, 0);
    pulseClr();
    checkOutput("t2_overrun_cleared", overrun, 0);

    // Low stop bit, then a clean frame.
    applyStimulus(8'h3C, 1'b0, 16);
    idle(4);
    checkOutput("t3_frame_err", frameErr, 1);
    checkOutput("t3_count", fifoCount, 0);
    applyStimulus(8'h3C, 1'b1, 16);
    expQ.push_back(8'h3C);
    idle(4);
    checkOutput("t3_count_good", fifoCount, 1);
    popByte("t3_pop");
    pulseClr();
    checkOutput("t3_frame_err_cleared", frameErr, 0);

    // Five-clock glitch must be rejected as a false start.
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    checkOutput("t4_valid", rxValid, 0);
    checkOutput("t4_overrun", overrun, 0);
    checkOutput("t4_frame_err", frameErr, 0);
    applyStimulus(8'h5A, 1'b1, 16);
    expQ.push_back(8'h5A);
    idle(4);
    popByte("t4_pop");

    // Reset in the middle of frame 0x55 with a byte already buffered; RX stays low through reset.
    applyStimulus(8'h11, 1'b1, 16);
    idle(4);
    checkOutput("t5_prefill", fifoCount, 1);
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(16);
    rx = 1'b0;
    idle(8);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(30);
    rx = 1'b1;
    idle(200);
    checkOutput("t5_count", fifoCount, 0);
    checkOutput("t5_valid", rxValid, 0);
    checkOutput("t5_overrun", overrun, 0);
    checkOutput("t5_frame_err", frameErr, 0);
    applyStimulus(8'hC3, 1'b1, 16);
    expQ.push_back(8'hC3);
    idle(4);
    popByte("t5_pop");

    // Full FIFO with a pop in the same cycle as the ninth byte's stop sample.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h60 + 8'(i), 1'b1, 16);
      expQ.push_back(8'h60 + 8'(i));
    end
    idle(4);
    checkOutput("t6_full", fifoCount, 8);
    fork
      applyStimulus(8'h68, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        repeat (154) @(posedge clk);
        #1;
        headByte = expQ.pop_front();
        checkOutput("t6_head_at_stop", rxData, headByte);
        rdEn = 1'b1;
        @(posedge clk);
        #1;
        rdEn = 1'b0;
      end
    join
    expQ.push_back(8'h68);
    idle(4);
    checkOutput("t6_count", fifoCount, 8);
    checkOutput("t6_overrun", overrun, 0);
    for (int i = 0; i < 8; i++) popByte("t6_pop");
    checkOutput("t6_empty", rxValid, 0);

    // Minimum divisor, frames back to back.
    baudDiv = 16'd4;
    applyStimulus(8'hFF, 1'b1, 4);
    applyStimulus(8'h00, 1'b1, 4);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h00);
    idle(10);
    checkOutput("t7_count", fifoCount, 2);
    checkOutput("t7_overrun", overrun, 0);
    checkOutput("t7_frame_err", frameErr, 0);
    popByte("t7_pop");
    popByte("t7_pop");
    checkOutput("t7_empty", rxValid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
